// File: rtl/intirvx_decode_stage.sv
// RV32 decode stage: combinational decode of the incoming word feeding a
// DEPTH-entry FIFO of decoded entries, plus a saturating illegal-instruction count.
module intirvx_decode_stage #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int RV_M  = 0,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_unit,
    output logic [2:0]       out_sub_unit,
    output logic [2:0]       out_sel,
    output logic             out_imm,
    output logic             out_jal,
    output logic             out_branch,
    output logic             out_fence,
    output logic             out_ecall,
    output logic             out_ebreak,
    output logic             out_mret,
    output logic             out_illegal,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_pc,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0]      unit;
        logic [2:0]      sub_unit;
        logic [2:0]      sel;
        logic            imm;
        logic            jal;
        logic            branch;
        logic            fence;
        logic            ecall;
        logic            ebreak;
        logic            mret;
        logic            illegal;
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t        dec;
    entry_t        head;
    entry_t        mem [DEPTH];
    logic          bad;
    logic [6:0]    opcode;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    always_comb begin
        dec = '0;
        bad = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (opcode)
                7'b0110111: dec.imm = 1'b1;
                7'b0010111: begin dec.sel = 3'd1; dec.imm = 1'b1; end
                7'b1101111: begin dec.sel = 3'd2; dec.imm = 1'b1; dec.jal = 1'b1; end
                7'b1100111: begin
                    if (f3 == 3'd0) begin
                        dec.sel = 3'd3; dec.imm = 1'b1; dec.branch = 1'b1;
                    end else bad = 1'b1;
                end
                7'b1100011: begin
                    dec.sub_unit = 3'd1; dec.imm = 1'b1; dec.branch = 1'b1;
                    case (f3)
                        3'd0: dec.sel = 3'd0;
                        3'd1: dec.sel = 3'd1;
                        3'd4: dec.sel = 3'd2;
                        3'd5: dec.sel = 3'd3;
                        3'd6: dec.sel = 3'd4;
                        3'd7: dec.sel = 3'd5;
                        default: bad = 1'b1;
                    endcase
                end
                7'b0000011: begin
                    dec.unit = 2'd1; dec.imm = 1'b1;
                    case (f3)
                        3'd0: dec.sel = 3'd0;
                        3'd1: dec.sel = 3'd1;
                        3'd2: dec.sel = 3'd2;
                        3'd4: dec.sel = 3'd3;
                        3'd5: dec.sel = 3'd4;
                        default: bad = 1'b1;
                    endcase
                end
                7'b0100011: begin
                    dec.unit = 2'd1; dec.sub_unit = 3'd1; dec.imm = 1'b1;
                    if (f3 <= 3'd2) dec.sel = f3;
                    else bad = 1'b1;
                end
                7'b0010011: begin
                    dec.imm = 1'b1;
                    case (f3)
                        3'd0: dec.sub_unit = 3'd2;
                        3'd1: begin
                            dec.sub_unit = 3'd4;
                            if (f7 != 7'b0000000) bad = 1'b1;
                        end
                        3'd5: begin
                            dec.sub_unit = 3'd4;
                            if (f7 == 7'b0000000) dec.sel = 3'd1;
                            else if (f7 == 7'b0100000) dec.sel = 3'd2;
                            else bad = 1'b1;
                        end
                        3'd2: begin dec.sub_unit = 3'd3; dec.sel = 3'd0; end
                        3'd3: begin dec.sub_unit = 3'd3; dec.sel = 3'd1; end
                        3'd4: begin dec.sub_unit = 3'd3; dec.sel = 3'd2; end
                        3'd6: begin dec.sub_unit = 3'd3; dec.sel = 3'd3; end
                        default: begin dec.sub_unit = 3'd3; dec.sel = 3'd4; end
                    endcase
                end
                7'b0110011: begin
                    if (f7 == 7'b0000000) begin
                        case (f3)
                            3'd0: dec.sub_unit = 3'd2;
                            3'd1: dec.sub_unit = 3'd4;
                            3'd2: begin dec.sub_unit = 3'd3; dec.sel = 3'd0; end
                            3'd3: begin dec.sub_unit = 3'd3; dec.sel = 3'd1; end
                            3'd4: begin dec.sub_unit = 3'd3; dec.sel = 3'd2; end
                            3'd5: begin dec.sub_unit = 3'd4; dec.sel = 3'd1; end
                            3'd6: begin dec.sub_unit = 3'd3; dec.sel = 3'd3; end
                            default: begin dec.sub_unit = 3'd3; dec.sel = 3'd4; end
                        endcase
                    end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
                        dec.sub_unit = 3'd2; dec.sel = 3'd1;
                    end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
                        dec.sub_unit = 3'd4; dec.sel = 3'd2;
                    end else if (RV_M != 0 && f7 == 7'b0000001) begin
                        // f3[2] splits MUL* from DIV/REM; low bits pick the variant
                        dec.unit     = 2'd3;
                        dec.sub_unit = {2'b00, f3[2]};
                        dec.sel      = {1'b0, f3[1:0]};
                    end else bad = 1'b1;
                end
                7'b0001111: begin
                    dec.fence = 1'b1;
                    if (f3 == 3'd1) dec.imm = 1'b1;
                    else if (f3 != 3'd0) bad = 1'b1;
                end
                7'b1110011: begin
                    case (f3)
                        3'd1, 3'd2, 3'd3: begin dec.unit = 2'd2; dec.sel = f3 - 3'd1; end
                        3'd5, 3'd6, 3'd7: begin
                            dec.unit = 2'd2; dec.sel = f3 - 3'd5; dec.imm = 1'b1;
                        end
                        3'd0: begin
                            if (in_inst == 32'h0000_0073) dec.ecall = 1'b1;
                            else if (in_inst == 32'h0010_0073) dec.ebreak = 1'b1;
                            else if (in_inst == 32'h3020_0073) dec.mret = 1'b1;
                            else bad = 1'b1;
                        end
                        default: bad = 1'b1;
                    endcase
                end
                default: bad = 1'b1;
            endcase
        end
        if (bad) begin
            dec = '0;
            dec.illegal = 1'b1;
        end
        dec.inst = in_inst;
        dec.pc   = in_pc;
    end

    assign in_ready  = (count < CW'(DEPTH)) && !flush && reset_n;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            illegal_cnt <= '0;
        end else begin
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= bump(wr_ptr);
                if (pop) rd_ptr <= bump(rd_ptr);
                if (push && !pop) count <= count + CW'(1);
                else if (pop && !push) count <= count - CW'(1);
            end
            if (push && dec.illegal && illegal_cnt != '1)
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    // Entry storage needs no reset; it is only observed while count says it is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head         = out_valid ? mem[rd_ptr] : '0;
    assign out_unit     = head.unit;
    assign out_sub_unit = head.sub_unit;
    assign out_sel      = head.sel;
    assign out_imm      = head.imm;
    assign out_jal      = head.jal;
    assign out_branch   = head.branch;
    assign out_fence    = head.fence;
    assign out_ecall    = head.ecall;
    assign out_ebreak   = head.ebreak;
    assign out_mret     = head.mret;
    assign out_illegal  = head.illegal;
    assign out_inst     = head.inst;
    assign out_pc       = head.pc;
endmodule

// File: tb/tb_intirvx_decode_stage.sv
// Directed bench for intirvx_decode_stage: dut_a has RV_M=1, CNT_W=16;
// dut_b shares its inputs with RV_M=0, CNT_W=2.
module tb_intirvx_decode_stage;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;

    logic        a_in_ready, a_out_valid, a_imm, a_jal, a_branch, a_fence;
    logic        a_ecall, a_ebreak, a_mret, a_illegal;
    logic [1:0]  a_unit;
    logic [2:0]  a_sub, a_sel;
    logic [31:0] a_inst, a_pc;
    logic [15:0] a_illegal_cnt;
    logic        b_in_ready, b_out_valid, b_imm, b_jal, b_branch, b_fence;
    logic        b_ecall, b_ebreak, b_mret, b_illegal;
    logic [1:0]  b_unit;
    logic [2:0]  b_sub, b_sel;
    logic [31:0] b_inst, b_pc;
    logic [1:0]  b_illegal_cnt;
    logic [15:0] a_fields, b_fields;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    intirvx_decode_stage #(.DEPTH(2), .XLEN(32), .RV_M(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_unit(a_unit),
        .out_sub_unit(a_sub), .out_sel(a_sel), .out_imm(a_imm), .out_jal(a_jal),
        .out_branch(a_branch), .out_fence(a_fence), .out_ecall(a_ecall),
        .out_ebreak(a_ebreak), .out_mret(a_mret), .out_illegal(a_illegal),
        .out_inst(a_inst), .out_pc(a_pc), .illegal_cnt(a_illegal_cnt)
    );

    intirvx_decode_stage #(.DEPTH(2), .XLEN(32), .RV_M(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_unit(b_unit),
        .out_sub_unit(b_sub), .out_sel(b_sel), .out_imm(b_imm), .out_jal(b_jal),
        .out_branch(b_branch), .out_fence(b_fence), .out_ecall(b_ecall),
        .out_ebreak(b_ebreak), .out_mret(b_mret), .out_illegal(b_illegal),
        .out_inst(b_inst), .out_pc(b_pc), .illegal_cnt(b_illegal_cnt)
    );

    // Flags order: jal, branch, fence, ecall, ebreak, mret, illegal
    assign a_fields = {a_unit, a_sub, a_sel, a_imm, a_jal, a_branch, a_fence,
                       a_ecall, a_ebreak, a_mret, a_illegal};
    assign b_fields = {b_unit, b_sub, b_sel, b_imm, b_jal, b_branch, b_fence,
                       b_ecall, b_ebreak, b_mret, b_illegal};

    function automatic logic [15:0] ef(input int u, input int s, input int l,
                                       input int m, input logic [6:0] fl);
        logic [31:0] uu, ss, ll, mm;
        uu = u; ss = s; ll = l; mm = m;
        return {uu[1:0], ss[2:0], ll[2:0], mm[0], fl};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b1; in_inst = 32'h0050_0093;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %0b want 0", a_in_ready); end
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %0b want 0", a_out_valid); end
        n_cmp++;
        if (a_illegal_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", a_illegal_cnt); end
        n_cmp++;
        if (a_fields !== 16'h0 || a_inst !== 32'h0 || a_pc !== 32'h0) begin
            n_fail++; $display("[TB] FAIL reset_data: fields %h inst %h pc %h want 0", a_fields, a_inst, a_pc);
        end
        reset_n = 1'b1; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ready: got %0b want 1", a_in_ready); end
    endtask

    task automatic test_decode;
        logic [31:0] words[$];
        logic [15:0] exps[$];
        string       names[$];
        logic [31:0] pc;
        words = '{32'h0050_0093, 32'h4010_D093, 32'h0010_D093, 32'h0000_10B7, 32'h0000_1097,
                  32'h0080_00EF, 32'h0000_80E7, 32'h0020_F463, 32'h0000_D083, 32'h0010_A023,
                  32'h4020_8033, 32'h4020_D033, 32'h0010_B093, 32'h0020_F033, 32'h3000_F073,
                  32'h3000_2073, 32'h0FF0_000F, 32'h0000_100F, 32'h0000_0073, 32'h0010_0073,
                  32'h3020_0073, 32'h0220_D033, 32'h0220_F033, 32'h0000_0001, 32'h0420_8033,
                  32'h0210_9093, 32'h0020_8063};
        exps = '{ef(0,2,0,1,7'b0), ef(0,4,2,1,7'b0), ef(0,4,1,1,7'b0), ef(0,0,0,1,7'b0),
                 ef(0,0,1,1,7'b0), ef(0,0,2,1,7'b1000000), ef(0,0,3,1,7'b0100000),
                 ef(0,1,5,1,7'b0100000), ef(1,0,4,1,7'b0), ef(1,1,2,1,7'b0),
                 ef(0,2,1,0,7'b0), ef(0,4,2,0,7'b0), ef(0,3,1,1,7'b0), ef(0,3,4,0,7'b0),
                 ef(2,0,2,1,7'b0), ef(2,0,1,0,7'b0), ef(0,0,0,0,7'b0010000),
                 ef(0,0,0,1,7'b0010000), ef(0,0,0,0,7'b0001000), ef(0,0,0,0,7'b0000100),
                 ef(0,0,0,0,7'b0000010), ef(3,1,1,0,7'b0), ef(3,1,3,0,7'b0),
                 ef(0,0,0,0,7'b0000001), ef(0,0,0,0,7'b0000001), ef(0,0,0,0,7'b0000001),
                 ef(0,1,0,1,7'b0100000)};
        names = '{"ADDI", "SRAI", "SRLI", "LUI", "AUIPC", "JAL", "JALR", "BGEU", "LHU", "SW",
                  "SUB", "SRA", "SLTIU", "AND", "CSRRCI", "CSRRS", "FENCE", "FENCE_I",
                  "ECALL", "EBREAK", "MRET", "DIVU", "REMU", "CINSN", "BAD_F7", "SLLI_B25",
                  "BEQ"};
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < words.size(); i++) begin
            pc = 32'h100 + 32'(i * 4);
            in_inst = words[i]; in_pc = pc;
            tick();
            n_cmp++;
            if (a_out_valid !== 1'b1 || a_fields !== exps[i] || a_inst !== words[i] || a_pc !== pc) begin
                n_fail++;
                $display("[TB] FAIL dec_%s: got v%0b f%h i%h pc%h want v1 f%h i%h pc%h", names[i],
                         a_out_valid, a_fields, a_inst, a_pc, exps[i], words[i], pc);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (a_illegal_cnt !== 16'd3) begin n_fail++; $display("[TB] FAIL dec_cnt: got %0d want 3", a_illegal_cnt); end
        n_cmp++;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL dec_drain: got %0b want 0", a_out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_mul;
        do_reset();
        in_valid = 1'b1; in_inst = 32'h0220_8033; in_pc = 32'h40;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (a_fields !== ef(3,0,0,0,7'b0)) begin n_fail++; $display("[TB] FAIL mul_m1: got %h want %h", a_fields, ef(3,0,0,0,7'b0)); end
        n_cmp++;
        if (b_fields !== ef(0,0,0,0,7'b0000001) || b_pc !== 32'h40) begin
            n_fail++; $display("[TB] FAIL mul_m0: got %h pc %h want %h pc 40", b_fields, b_pc, ef(0,0,0,0,7'b1));
        end
        n_cmp++;
        if (b_illegal_cnt !== 2'd1 || a_illegal_cnt !== 16'd0) begin
            n_fail++; $display("[TB] FAIL mul_cnt: got b%0d a%0d want b1 a0", b_illegal_cnt, a_illegal_cnt);
        end
    endtask

    task automatic test_back_pressure;
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h0050_0093; in_pc = 32'h10;
        tick();
        n_cmp++;
        if (a_in_ready !== 1'b1 || a_pc !== 32'h10) begin n_fail++; $display("[TB] FAIL bp_first: ready %0b pc %h want 1 10", a_in_ready, a_pc); end
        in_inst = 32'h4020_8033; in_pc = 32'h14;
        tick();
        n_cmp++;
        if (a_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full: got %0b want 0", a_in_ready); end
        in_inst = 32'h0020_F033; in_pc = 32'h18;
        tick();
        n_cmp++;
        if (a_pc !== 32'h10 || a_fields !== ef(0,2,0,1,7'b0)) begin n_fail++; $display("[TB] FAIL bp_hold: pc %h f %h want 10 %h", a_pc, a_fields, ef(0,2,0,1,7'b0)); end
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (a_pc !== 32'h14 || a_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_no_bypass: pc %h ready %0b want 14 1", a_pc, a_in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_pc !== 32'h18 || a_inst !== 32'h0020_F033) begin
            n_fail++; $display("[TB] FAIL bp_third: v %0b pc %h inst %h want 1 18 0020f033", a_out_valid, a_pc, a_inst);
        end
        tick();
        n_cmp++;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_empty: got %0b want 0", a_out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush;
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h0000_0000; in_pc = 32'h20;
        tick();
        in_inst = 32'h0050_0093; in_pc = 32'h24;
        tick();
        n_cmp++;
        if (a_illegal_cnt !== 16'd1 || a_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_setup: cnt %0d ready %0b want 1 0", a_illegal_cnt, a_in_ready); end
        flush = 1'b1; out_ready = 1'b1; in_inst = 32'h0000_10B7; in_pc = 32'h28;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL fl_empty: v %0b pc %h want 0 0", a_out_valid, a_pc); end
        n_cmp++;
        if (a_illegal_cnt !== 16'd1 || a_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fl_keep_cnt: cnt %0d ready %0b want 1 1", a_illegal_cnt, a_in_ready); end
        in_valid = 1'b1;
        tick();
        n_cmp++;
        if (a_pc !== 32'h28 || a_fields !== ef(0,0,0,1,7'b0)) begin n_fail++; $display("[TB] FAIL fl_reuse: pc %h f %h want 28 %h", a_pc, a_fields, ef(0,0,0,1,7'b0)); end
        flush = 1'b1; in_inst = 32'h0000_1097; in_pc = 32'h2C;
        #1;
        n_cmp++;
        if (a_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_ready: got %0b want 0", a_in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fl_no_accept: got %0b want 0", a_out_valid); end
    endtask

    task automatic test_saturate;
        logic [1:0] want;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0000_0000; in_pc = 32'h60;
        for (int i = 0; i < 5; i++) begin
            tick();
            want = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_cmp++;
            if (b_illegal_cnt !== want) begin n_fail++; $display("[TB] FAIL sat_%0d: got %0d want %0d", i, b_illegal_cnt, want); end
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (b_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_rst_ready: got %0b want 0", b_in_ready); end
        tick();
        n_cmp++;
        if (b_illegal_cnt !== 2'd0 || b_out_valid !== 1'b0 || a_illegal_cnt !== 16'd0) begin
            n_fail++; $display("[TB] FAIL sat_rst: b_cnt %0d b_v %0b a_cnt %0d want 0 0 0", b_illegal_cnt, b_out_valid, a_illegal_cnt);
        end
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul();
        test_back_pressure();
        test_flush();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
